si5341_cfg_seq: RTL
===================

SI5341_CFG_SEQ -- requirements
Module: si5341_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'hE8: I2C device address byte, write form, sent first in every transaction.
REQ-002 Parameter NUM_REGS, default 16'd512: number of table entries, range 0..65535.
REQ-003 Parameter DELAY_UNIT, default 50_000: clock cycles per delay tick (1 ms at 50 MHz).
REQ-004 Parameter TIMEOUT, default 1_000_000: maximum clock cycles allowed between wr_req assertion or the previous wr_done and the next wr_done.
REQ-005 Parameter GAP, default 16: minimum clock cycles wr_req is held low between transactions.
REQ-006 clk  in  1  single system clock; every register is updated on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 start  in  1  one-cycle pulse that begins a configuration pass.
REQ-009 rom_addr  out  16  table entry index.
REQ-010 rom_data  in  24  table entry {reg_addr[15:0], value[7:0]}, valid exactly 1 cycle after rom_addr changes.
REQ-011 wr_req  out  1  held high for the whole multi-byte I2C write transaction.
REQ-012 wr_data  out  8  byte currently offered to the I2C byte engine.
REQ-013 wr_done  in  1  one-cycle pulse from the I2C byte engine when the offered byte has been sent and ACKed.
REQ-014 busy  out  1  high from the cycle after an accepted start until done or err asserts.
REQ-015 done  out  1  one-cycle pulse when all entries have been written.
REQ-016 err  out  1  sticky timeout flag, cleared by rst or by an accepted start.

Function
REQ-017 The FSM SHALL use these states: IDLE, FETCH, DECODE, PAGE_WR, REG_WR, GAP_WAIT, DELAY, FINISH, ERROR.
REQ-018 In IDLE, a start pulse SHALL clear err, clear the page cache, set rom_addr=0 and move to FETCH; while busy=1, start SHALL be ignored.
REQ-019 FETCH SHALL last 1 cycle. DECODE SHALL then sample rom_data.
REQ-020 In DECODE, if reg_addr==16'hFFFF the FSM SHALL enter DELAY; if the page cache is invalid or reg_addr[15:8] differs from it, the FSM SHALL enter PAGE_WR; otherwise it SHALL enter REG_WR.
REQ-021 PAGE_WR SHALL send bytes DEV_ADDR, 8'h01, reg_addr[15:8] in one transaction, then update the cache and mark it valid after the third wr_done.
REQ-022 REG_WR SHALL send bytes DEV_ADDR, reg_addr[7:0], value in one transaction.
REQ-023 wr_data SHALL present byte 0 in the same cycle wr_req rises, and SHALL change to the next byte in the cycle after each wr_done; wr_req SHALL fall in the cycle after the third wr_done.
REQ-024 After each transaction the FSM SHALL spend GAP cycles in GAP_WAIT with wr_req=0. It SHALL then go to REG_WR (after a page write) or advance to the next entry (after a register write).
REQ-025 DELAY SHALL hold wr_req=0 for value*DELAY_UNIT cycles (value=0 gives 1 cycle) and then advance to the next entry; the page cache SHALL be unaffected.
REQ-026 Advance SHALL increment rom_addr and go to FETCH; when rom_addr+1==NUM_REGS the FSM SHALL go to FINISH instead; with NUM_REGS=0, start SHALL go directly to FINISH.
REQ-027 FINISH SHALL pulse done for 1 cycle, deassert busy and return to IDLE.
REQ-028 The timeout counter SHALL count while wr_req=1 and restart at 0 on each wr_done; on reaching TIMEOUT the FSM SHALL enter ERROR, drop wr_req in the next cycle, set err, deassert busy and return to IDLE.
REQ-029 wr_done received while wr_req=0 SHALL be ignored.
REQ-030 A 32-bit delay counter and the timeout counter SHALL saturate and never wrap.

Reset
REQ-031 On rst=1 at a clock edge, all state SHALL be forced to IDLE with wr_req=0, wr_data=8'h00, rom_addr=0, busy=0, done=0, err=0 and the page cache invalid, including mid-transaction; wr_req SHALL be low in the cycle after rst is sampled.

Verification
REQ-032 Table {0x0B24,0xC0},{0x0B25,0x00}, NUM_REGS=2 -> byte stream E8,01,0B | E8,24,C0 | E8,25,00 with only one page write, wr_req low ≥GAP cycles between transactions, then one done pulse.
REQ-033 Table {0x0B24,0xC0},{0x0C00,0x01} -> E8,01,0B | E8,24,C0 | E8,01,0C | E8,00,01.
REQ-034 Entry {0xFFFF,0x03} with DELAY_UNIT=10 -> wr_req low for exactly 30 DELAY cycles, and no page rewrite afterwards when the page is unchanged.
REQ-035 wr_done never returned, TIMEOUT=100 -> err=1 and wr_req=0 within 102 cycles of wr_req rising, busy=0, no done pulse.
REQ-036 rst asserted after the second wr_done of REG_WR -> next cycle wr_req=0 and busy=0; a new start replays from entry 0 beginning with a page write.
REQ-037 start pulsed while busy=1, then NUM_REGS=0 start from idle -> first start ignored with the stream unchanged; second start gives done one cycle later with no wr_req activity.

Source files
------------

// File: rtl/si5341_cfg_seq.sv
// Walks a register table and writes each entry to an Si5341 over a byte-oriented I2C engine,
// issuing page-select writes only when the register page changes and honouring delay entries.
module si5341_cfg_seq #(
  parameter logic [7:0]  DEV_ADDR   = 8'hE8,
  parameter int unsigned NUM_REGS   = 512,
  parameter int unsigned DELAY_UNIT = 50_000,
  parameter int unsigned TIMEOUT    = 1_000_000,
  parameter int unsigned GAP        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        wr_req,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, PAGE_WR, REG_WR, GAP_WAIT, DELAY, FINISH, ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ent_addr;
  logic [7:0]  ent_val;
  logic [7:0]  page;
  logic        page_vld;
  logic        after_page;
  logic [1:0]  bidx;
  logic [31:0] cnt, dlen, tcnt;
  logic        txn_end, timeout, gap_end, dly_end, last;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign txn_end = wr_done && (bidx == 2'd2);
  assign timeout = !wr_done && (({1'b0, tcnt} + 33'd1) >= 33'(TIMEOUT));
  assign gap_end = ({1'b0, cnt} + 33'd1) >= 33'(GAP);
  assign dly_end = ({1'b0, cnt} + 33'd1) >= {1'b0, dlen};
  assign last    = ({16'd0, rom_addr} + 32'd1) == NUM_REGS;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = (NUM_REGS == 0) ? FINISH : FETCH;
      FETCH:    state_nxt = DECODE;
      DECODE: begin
        if (rom_data[23:8] == 16'hFFFF)                state_nxt = DELAY;
        else if (!page_vld || rom_data[23:16] != page) state_nxt = PAGE_WR;
        else                                           state_nxt = REG_WR;
      end
      PAGE_WR, REG_WR: begin
        wr_req = 1'b1;
        if (timeout)      state_nxt = ERROR;
        else if (txn_end) state_nxt = GAP_WAIT;
      end
      GAP_WAIT: if (gap_end) state_nxt = after_page ? REG_WR : (last ? FINISH : FETCH);
      DELAY:    if (dly_end) state_nxt = last ? FINISH : FETCH;
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERROR:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Byte 0 is always the device address; bytes 1-2 depend on page-select vs register write.
  always_comb begin
    wr_data = 8'h00;
    if (wr_req) begin
      case (bidx)
        2'd0:    wr_data = DEV_ADDR;
        2'd1:    wr_data = (state == PAGE_WR) ? 8'h01 : ent_addr[7:0];
        2'd2:    wr_data = (state == PAGE_WR) ? ent_addr[15:8] : ent_val;
        default: wr_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr   <= '0;
      page_vld   <= 1'b0;
      after_page <= 1'b0;
      bidx       <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      busy <= !(state_nxt inside {IDLE, FINISH, ERROR});
      if (state == IDLE && start) begin
        rom_addr <= '0;
        page_vld <= 1'b0;
        err      <= 1'b0;
      end else if (state_nxt == FETCH) begin
        rom_addr <= rom_addr + 16'd1;
      end
      if (state_nxt == ERROR) err <= 1'b1;
      if (wr_req && txn_end) begin
        after_page <= (state == PAGE_WR);
        if (state == PAGE_WR) page_vld <= 1'b1;
      end
      if (!wr_req)      bidx <= '0;
      else if (wr_done) bidx <= (bidx == 2'd2) ? 2'd0 : bidx + 2'd1;
      // cnt times the current GAP_WAIT/DELAY visit; tcnt times the wait for the next ACK.
      cnt  <= (state_nxt != state) ? '0 : sat_inc(cnt);
      tcnt <= (!wr_req || wr_done) ? '0 : sat_inc(tcnt);
    end
  end

  always_ff @(posedge clk) begin
    if (state == DECODE) begin
      ent_addr <= rom_data[23:8];
      ent_val  <= rom_data[7:0];
      dlen     <= 32'(rom_data[7:0]) * DELAY_UNIT;
    end
    if (state == PAGE_WR && txn_end) page <= ent_addr[15:8];
  end

endmodule
